issue_window_queue: RTL and testbench

//  In-order issue queue feeding the four-wide RAW/WAR hazard checker.

---
 rtl/issue_window_queue_if.sv | 41 ++++
 rtl/issue_window_queue.sv | 102 ++++++++++
 tb/tb_issue_window_queue.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/issue_window_queue_if.sv
// Issue window queue bus: push side, four-slot window to the hazard checker,
// checker flags back, and the issue result.
//   master : upstream decode / checker / execute side (drives push, flags, exe_ready, flush)
//   slave  : the queue itself (drives push_ready, window slots, issue_vec/issue_cnt)
// Window slot N (1..4) is element [N-1] of des/s1/s2/op/ins_in.
interface issue_window_queue_if #(
  parameter int DES_W = 4,
  parameter int SRC_W = 4,
  parameter int OP_W  = 8
);
  logic                  flush;
  logic                  push_valid;
  logic                  push_ready;
  logic [DES_W-1:0]      push_des;
  logic [SRC_W-1:0]      push_s1;
  logic [SRC_W-1:0]      push_s2;
  logic [OP_W-1:0]       push_op;
  logic [3:0][DES_W-1:0] des;
  logic [3:0][SRC_W-1:0] s1;
  logic [3:0][SRC_W-1:0] s2;
  logic [3:0][OP_W-1:0]  op;
  logic [3:0]            ins_in;
  logic                  ins_flag_2;
  logic                  ins_flag_3;
  logic                  ins_flag_4;
  logic                  exe_ready;
  logic [3:0]            issue_vec;
  logic [2:0]            issue_cnt;

  modport master (
    output flush, push_valid, push_des, push_s1, push_s2, push_op,
           ins_flag_2, ins_flag_3, ins_flag_4, exe_ready,
    input  push_ready, des, s1, s2, op, ins_in, issue_vec, issue_cnt
  );

  modport slave (
    input  flush, push_valid, push_des, push_s1, push_s2, push_op,
           ins_flag_2, ins_flag_3, ins_flag_4, exe_ready,
    output push_ready, des, s1, s2, op, ins_in, issue_vec, issue_cnt
  );
endinterface

// File: rtl/issue_window_queue.sv
// In-order issue queue for the four-wide hazard checker.
// Buffers decoded instructions, presents the four oldest as window slots 1-4,
// and pops the longest in-order hazard-free prefix when execute is ready.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (pointers/count only, storage not cleared)
//   bus   : issue_window_queue_if.slave (push, window, checker flags, issue result, flush)
module issue_window_queue #(
  parameter int DES_W = 4,
  parameter int SRC_W = 4,
  parameter int OP_W  = 8,
  parameter int DEPTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  issue_window_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int EW = DES_W + 2 * SRC_W + OP_W;

  typedef logic [EW-1:0] entry_t;

  entry_t                mem_q [DEPTH];
  logic [PW-1:0]         head_q, head_d;
  logic [PW-1:0]         tail_q, tail_d;
  logic [PW:0]           count_q, count_d;
  logic                  push_acc;
  logic [3:0]            slot_vld;
  logic [3:0]            issue_vec;
  logic [2:0]            issue_cnt;
  logic [3:0][DES_W-1:0] des_w;
  logic [3:0][SRC_W-1:0] s1_w;
  logic [3:0][SRC_W-1:0] s2_w;
  logic [3:0][OP_W-1:0]  op_w;

  // Ready looks only at the registered count; a same-cycle pop does not free a slot early.
  assign bus.push_ready = (count_q != (PW+1)'(DEPTH));
  assign push_acc       = bus.push_valid && bus.push_ready;

  always_comb begin
    slot_vld = '0;
    des_w    = '0;
    s1_w     = '0;
    s2_w     = '0;
    op_w     = '0;
    for (int n = 0; n < 4; n++) begin
      slot_vld[n] = (count_q > (PW+1)'(n));
      if (slot_vld[n]) begin
        {des_w[n], s1_w[n], s2_w[n], op_w[n]} = mem_q[head_q + PW'(n)];
      end
    end
  end

  assign bus.ins_in = slot_vld;
  assign bus.des    = des_w;
  assign bus.s1     = s1_w;
  assign bus.s2     = s2_w;
  assign bus.op     = op_w;

  // Flags are qualified by slot validity so a flag on an empty slot can never
  // pop more entries than the queue holds.
  always_comb begin
    issue_vec[0] = bus.exe_ready && slot_vld[0];
    issue_vec[1] = issue_vec[0] && slot_vld[1] && bus.ins_flag_2;
    issue_vec[2] = issue_vec[1] && slot_vld[2] && bus.ins_flag_3;
    issue_vec[3] = issue_vec[2] && slot_vld[3] && bus.ins_flag_4;
    issue_cnt    = 3'(issue_vec[0]) + 3'(issue_vec[1]) + 3'(issue_vec[2]) + 3'(issue_vec[3]);
  end

  assign bus.issue_vec = issue_vec;
  assign bus.issue_cnt = issue_cnt;

  // Flush wins over both the pop and the push of the same cycle.
  always_comb begin
    head_d  = head_q + PW'(issue_cnt);
    tail_d  = tail_q + PW'(push_acc);
    count_d = count_q + (PW+1)'(push_acc) - (PW+1)'(issue_cnt);
    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc && !bus.flush) begin
      mem_q[tail_q] <= {bus.push_des, bus.push_s1, bus.push_s2, bus.push_op};
    end
  end
endmodule

// File: tb/tb_issue_window_queue.sv
module tb_issue_window_queue;
  localparam int DEPTH = 16;

  typedef logic [19:0] ent_t;
  typedef struct packed {
    logic [3:0]       ins;
    logic [3:0][19:0] slot;
    logic [3:0]       vec;
    logic [2:0]       cnt;
    logic             rdy;
  } exp_t;

  logic clk;
  logic rst_n;

  issue_window_queue_if bus ();

  issue_window_queue dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  ent_t mq[$];
  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   stim_done = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  // Reference: the queue is a plain list; the window is its first four items;
  // the issue group is the longest run of valid slots from the front whose
  // checker flag (slot 1 needs none) is set, and nothing issues without exe_ready.
  function automatic exp_t predict(input bit [3:0] fl_v, input bit exe);
    exp_t e;
    int   n_iss;
    bit   stop;
    e = '0;
    e.rdy = (mq.size() != DEPTH);
    for (int n = 0; n < 4; n++) begin
      e.ins[n]  = (n < mq.size());
      e.slot[n] = e.ins[n] ? mq[n] : 20'h0;
    end
    n_iss = 0;
    stop  = !exe;
    for (int n = 0; n < 4; n++) begin
      if (!stop && e.ins[n] && fl_v[n]) n_iss++;
      else stop = 1'b1;
    end
    e.cnt = 3'(n_iss);
    e.vec = 4'((1 << n_iss) - 1);
    return e;
  endfunction

  // One clock cycle; called at posedge+1, returns at the next posedge+1.
  task automatic step(input bit pv, input ent_t pe, input bit f2, input bit f3,
                      input bit f4, input bit exe, input bit fl);
    exp_t e;
    bus.push_valid = pv;
    {bus.push_des, bus.push_s1, bus.push_s2, bus.push_op} = pe;
    bus.ins_flag_2 = f2;
    bus.ins_flag_3 = f3;
    bus.ins_flag_4 = f4;
    bus.exe_ready  = exe;
    bus.flush      = fl;
    e = predict({f4, f3, f2, 1'b1}, exe);
    exp_q.push_back(e);
    @(posedge clk);
    if (fl) mq.delete();
    else begin
      for (int k = 0; k < int'(e.cnt); k++) void'(mq.pop_front());
      if (pv && e.rdy) mq.push_back(pe);
    end
    #1;
  endtask

  task automatic push_n(input int n);
    for (int k = 0; k < n; k++) step(1'b1, ent_t'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    while (mq.size() > 0) step(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  // Asynchronous reset asserted between edges while issue conditions are active.
  task automatic reset_step();
    exp_t e;
    bus.push_valid = 1'b0;
    bus.exe_ready  = 1'b1;
    bus.ins_flag_2 = 1'b1;
    bus.ins_flag_3 = 1'b1;
    bus.ins_flag_4 = 1'b1;
    bus.flush      = 1'b0;
    rst_n = 1'b0;
    mq.delete();
    e = '0;
    e.rdy = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      for (int n = 0; n < 4; n++) begin
        chk($sformatf("ins%0d_in", n + 1), 32'(bus.ins_in[n]), 32'(e.ins[n]));
        chk($sformatf("slot%0d", n + 1),
            32'({bus.des[n], bus.s1[n], bus.s2[n], bus.op[n]}), 32'(e.slot[n]));
      end
      chk("issue_vec", 32'(bus.issue_vec), 32'(e.vec));
      chk("issue_cnt", 32'(bus.issue_cnt), 32'(e.cnt));
      chk("push_ready", 32'(bus.push_ready), 32'(e.rdy));
    end
  end

  initial begin
    rst_n          = 1'b0;
    bus.flush      = 1'b0;
    bus.push_valid = 1'b0;
    bus.push_des   = '0;
    bus.push_s1    = '0;
    bus.push_s2    = '0;
    bus.push_op    = '0;
    bus.ins_flag_2 = 1'b0;
    bus.ins_flag_3 = 1'b0;
    bus.ins_flag_4 = 1'b0;
    bus.exe_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // reset state, even with flags and exe_ready high
    step(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

    // full four-wide issue, then empty
    push_n(4);
    step(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

    // prefix stall: slot 4 flag set but blocked behind slot 3
    push_n(4);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();

    // full queue: dropped push, pop 1, then push with pop 2
    push_n(DEPTH);
    step(1'b1, ent_t'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, ent_t'($urandom), 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();

    // wrap: head at 14 with four entries, issue three
    reset_step();
    push_n(14);
    drain();
    push_n(4);
    step(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();

    // flush beats same-cycle push and issue
    push_n(3);
    step(1'b1, ent_t'($urandom), 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // reset mid-stream with five entries
    push_n(5);
    reset_step();
    step(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 99) < 60, ent_t'($urandom),
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7,
           $urandom_range(0, 99) < 2);
    end

    stim_done = 1'b1;
    repeat (2) @(posedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
